// File: rtl/execute_stage_muldiv_pkg.sv
// Shared types for the execute stage: ALU op classes, forward selects, muldiv ops and FSM states.
// Pure type/constant package; no latency and no flow control of its own.
package execute_stage_muldiv_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FW_RF  = 2'b00,
    FW_WB  = 2'b01,
    FW_MEM = 2'b10
  } fw_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic is_muldiv(input alu_op_e op, input logic [6:0] funct7);
    return (op == ALUOP_RTYPE) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/MUX_3to1.sv
// Three-way operand mux used for register-file / WB / MEM forwarding.
// Latency: combinational; backpressure: none.
module MUX_3to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  input  logic [W-1:0] in2_i,
  input  logic [1:0]   sel_i,
  output logic [W-1:0] out_o
);
  always_comb begin
    case (sel_i)
      2'b01:   out_o = in1_i;
      2'b10:   out_o = in2_i;
      default: out_o = in0_i;
    endcase
  end
endmodule

// File: rtl/alu.sv
// Single-cycle integer ALU.
// Latency: combinational; backpressure: none.
module alu
  import execute_stage_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_ctrl_e       ctrl_i,
  output logic [XLEN-1:0] y_o
);
  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_control_unit.sv
// Decodes ALU op class plus funct3/funct7[5] into a concrete ALU operation.
// Latency: combinational; backpressure: none.
module alu_control_unit
  import execute_stage_muldiv_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_5_i,
  output alu_ctrl_e   alu_ctrl_o
);
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD:    alu_ctrl_o = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // funct7[5] selects SUB only for register-register ops; I-type has no SUBI
          3'b000: alu_ctrl_o = ((alu_op_i == ALUOP_RTYPE) && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl_o = ALU_SLL;
          3'b010: alu_ctrl_o = ALU_SLT;
          3'b011: alu_ctrl_o = ALU_SLTU;
          3'b100: alu_ctrl_o = ALU_XOR;
          3'b101: alu_ctrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl_o = ALU_OR;
          3'b111: alu_ctrl_o = ALU_AND;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/execute_stage_muldiv_muldiv.sv
// Multi-cycle multiply/divide unit: FSM, multiplier stages and restoring divider.
// Latency: MUL_STAGES for multiply, XLEN+1 for divide; stalls the pipe from accept until DONE.
module muldiv_unit
  import execute_stage_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'((MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  logic accept;
  assign accept = (state_q == ST_IDLE) && start_i && !flush_i;

  // Multiplier reads live operands in IDLE so a single-stage multiply can finish at the next edge
  logic [2:0]        mul_op;
  logic [XLEN-1:0]   mul_a, mul_b, mul_res;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    mul_op  = (state_q == ST_IDLE) ? funct3_i : f3_q;
    mul_a   = (state_q == ST_IDLE) ? op_a_i : a_q;
    mul_b   = (state_q == ST_IDLE) ? op_b_i : b_q;
    mul_sa  = (mul_op == MD_MULH) || (mul_op == MD_MULHSU);
    mul_sb  = (mul_op == MD_MULH);
    prod    = {{XLEN{mul_sa & mul_a[XLEN-1]}}, mul_a} * {{XLEN{mul_sb & mul_b[XLEN-1]}}, mul_b};
    mul_res = (mul_op == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Restoring divider works on magnitudes; signs are reapplied on the final iteration
  logic            div_signed, neg_a, neg_b, ge;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] divisor, rem_diff, rem_n, quo_n, q_fin, r_fin, div_res;

  always_comb begin
    div_signed = !f3_q[0];
    neg_a      = div_signed & a_q[XLEN-1];
    neg_b      = div_signed & b_q[XLEN-1];
    divisor    = neg_b ? neg(b_q) : b_q;
    rem_sh     = {rem_q, quo_q[XLEN-1]};
    ge         = (rem_sh >= {1'b0, divisor});
    rem_diff   = rem_sh[XLEN-1:0] - divisor;
    rem_n      = ge ? rem_diff : rem_sh[XLEN-1:0];
    quo_n      = {quo_q[XLEN-2:0], ge};
    q_fin      = (neg_a ^ neg_b) ? neg(quo_n) : quo_n;
    r_fin      = neg_a ? neg(rem_n) : rem_n;
    if (b_q == '0) begin
      q_fin = '1;
      r_fin = a_q;
    end else if (div_signed && (a_q == MOST_NEG) && (b_q == '1)) begin
      q_fin = a_q;
      r_fin = '0;
    end
    div_res = f3_q[1] ? r_fin : q_fin;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          busy_o = 1'b1;
          f3_d   = funct3_i;
          a_d    = op_a_i;
          b_d    = op_b_i;
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = (!funct3_i[0] && op_a_i[XLEN-1]) ? neg(op_a_i) : op_a_i;
          if (funct3_i[2]) begin
            state_d = ST_DIV;
          end else if (MUL_STAGES == 1) begin
            state_d  = ST_DONE;
            result_d = mul_res;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        busy_o = 1'b1;
        if (cnt_q == MUL_LAST) begin
          state_d  = ST_DONE;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DIV: begin
        busy_o = 1'b1;
        quo_d  = quo_n;
        rem_d  = rem_n;
        if (cnt_q == DIV_LAST) begin
          state_d  = ST_DONE;
          result_d = div_res;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign idle_o   = (state_q == ST_IDLE);
  assign result_o = result_q;

endmodule

// File: rtl/execute_stage_muldiv.sv
// Execute stage: forwarding muxes, single-cycle ALU and a multi-cycle mul/div unit.
// Latency: ALU ops same cycle, mul/div per muldiv_unit; EX_stall_o freezes IF/ID/EX while busy.
module execute_stage_muldiv
  import execute_stage_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_valid_i,
  input  logic [XLEN-1:0] EX_rd_data1_i,
  input  logic [XLEN-1:0] EX_rd_data2_i,
  input  logic [XLEN-1:0] MEM_fwd_data_i,
  input  logic [XLEN-1:0] WB_fwd_data_i,
  input  logic [XLEN-1:0] EX_imm_i,
  input  logic [XLEN-1:0] EX_pc_i,
  input  logic [31:0]     EX_instruction_i,
  input  logic            EX_ALUOpSrc1_i,
  input  logic            EX_ALUOpSrc2_i,
  input  alu_op_e         EX_ALUOp_i,
  input  fw_sel_e         EX_forwardA_i,
  input  fw_sel_e         EX_forwardB_i,
  input  logic            EX_flush_i,
  output logic [XLEN-1:0] EX_result_o,
  output logic            EX_result_valid_o,
  output logic            EX_stall_o
);
  logic [XLEN-1:0] fw_a, fw_b, op_a, op_b, alu_y, md_res;
  logic            is_md, md_idle, md_busy, md_done;
  alu_ctrl_e       alu_ctrl;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{EX_instruction_i[24:15], EX_instruction_i[11:0]};

  MUX_3to1 #(.W(XLEN)) u_fwd_a (
    .in0_i (EX_rd_data1_i),
    .in1_i (WB_fwd_data_i),
    .in2_i (MEM_fwd_data_i),
    .sel_i (EX_forwardA_i),
    .out_o (fw_a)
  );

  MUX_3to1 #(.W(XLEN)) u_fwd_b (
    .in0_i (EX_rd_data2_i),
    .in1_i (WB_fwd_data_i),
    .in2_i (MEM_fwd_data_i),
    .sel_i (EX_forwardB_i),
    .out_o (fw_b)
  );

  assign op_a  = EX_ALUOpSrc1_i ? EX_pc_i : fw_a;
  assign op_b  = EX_ALUOpSrc2_i ? EX_imm_i : fw_b;
  assign is_md = is_muldiv(EX_ALUOp_i, EX_instruction_i[31:25]);

  alu_control_unit u_alu_ctrl (
    .alu_op_i   (EX_ALUOp_i),
    .funct3_i   (EX_instruction_i[14:12]),
    .funct7_5_i (EX_instruction_i[30]),
    .alu_ctrl_o (alu_ctrl)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .a_i    (op_a),
    .b_i    (op_b),
    .ctrl_i (alu_ctrl),
    .y_o    (alu_y)
  );

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (EX_valid_i && is_md),
    .flush_i  (EX_flush_i),
    .funct3_i (EX_instruction_i[14:12]),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .idle_o   (md_idle),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // New instructions only reach the ALU path while the mul/div unit is idle
  always_comb begin
    EX_result_o       = '0;
    EX_result_valid_o = 1'b0;
    if (md_done) begin
      EX_result_o       = md_res;
      EX_result_valid_o = 1'b1;
    end else if (md_idle && EX_valid_i && !is_md) begin
      EX_result_o       = alu_y;
      EX_result_valid_o = 1'b1;
    end
  end

  assign EX_stall_o = md_busy;

endmodule

// File: doc/execute_stage_muldiv.md
EXECUTE_STAGE_MULDIV -- requirements
Module: execute_stage_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter MUL_STAGES, default 2, multiply latency in cycles; legal range 1..4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port EX_valid_i  input  1  instruction present in EX this cycle.
REQ-006 SHALL have ports EX_rd_data1_i, EX_rd_data2_i  input  XLEN  register-file operands.
REQ-007 SHALL have ports MEM_fwd_data_i, WB_fwd_data_i  input  XLEN  forwarding sources.
REQ-008 SHALL have ports EX_imm_i, EX_pc_i, EX_instruction_i  input  XLEN/XLEN/32  immediate, PC, instruction word.
REQ-009 SHALL have ports EX_ALUOpSrc1_i, EX_ALUOpSrc2_i  input  1  select PC / immediate as operand 1 / 2.
REQ-010 SHALL have ports EX_ALUOp_i (alu_op_e), EX_forwardA_i and EX_forwardB_i (fw_sel_e)  input  ALU class and forward selects.
REQ-011 SHALL have port EX_flush_i  input  1  abort any in-flight operation.
REQ-012 SHALL have ports EX_result_o  output  XLEN; EX_result_valid_o  output  1; EX_stall_o  output  1 (freeze IF/ID/EX).

Function
REQ-013 Operand A SHALL be selected by forwardA (RF/MEM/WB), then by ALUOpSrc1 (PC); operand B by forwardB, then by ALUOpSrc2 (immediate).
REQ-014 An instruction SHALL be a muldiv op when EX_ALUOp_i is the R-type class and instruction[31:25]=7'b0000001; funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-015 Non-muldiv valid instruction: the result SHALL be combinational ALU output in the same cycle, EX_result_valid_o=1, and EX_stall_o=0.
REQ-016 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-017 Accept in IDLE with valid, muldiv and no flush (cycle T): operands, signs and funct3 SHALL be latched, and EX_stall_o SHALL be 1 combinationally in T.
REQ-018 A multiply accepted at T SHALL produce DONE at T+MUL_STAGES; for MUL_STAGES=1 the FSM SHALL go IDLE->DONE directly.
REQ-019 A divide SHALL take XLEN restoring iterations in DIV (T+1..T+XLEN), then DONE at T+XLEN+1; latency SHALL be fixed regardless of operand values.
REQ-020 EX_stall_o SHALL be 1 in every MUL/DIV cycle and 0 in DONE; DONE SHALL assert EX_result_valid_o for exactly one cycle with the registered result, then return to IDLE.
REQ-021 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU SHALL return the high XLEN bits with signed*signed, signed*unsigned and unsigned*unsigned interpretation respectively.
REQ-022 Divide by zero: quotient SHALL be all-ones (DIV and DIVU) and remainder SHALL be the dividend.
REQ-023 Signed overflow (most-negative / -1): quotient SHALL be the dividend and remainder 0.
REQ-024 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-025 EX_valid_i, operand and forward inputs SHALL be ignored while in MUL/DIV/DONE.
REQ-026 EX_flush_i in any state SHALL force IDLE on the next edge, with no result_valid; flush in the accept cycle SHALL prevent acceptance and hold stall at 0.
REQ-027 EX_result_o SHALL be 0 whenever EX_result_valid_o is 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, iteration and stage counters to 0, result register to 0, EX_stall_o=0 and EX_result_valid_o=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; the first valid instruction after release SHALL be accepted normally.

Structure
REQ-030 Package defines SHALL hold muldiv_op_e, md_state_e and the constant FUNCT7_MULDIV=7'b0000001.
REQ-031 FSM, multiplier pipeline and divider SHALL live in a sub-module muldiv_unit; the block SHALL reuse the existing alu, alu_control_unit and MUX_3to1.

Verification
REQ-032 ADD x=5,y=7 with valid=1 -> same cycle: result=12, valid=1, stall=0.
REQ-033 MUL 0xFFFFFFFF*0xFFFFFFFF, MUL_STAGES=2 -> stall high 2 cycles, result=0x00000001 at T+2; MULHU -> 0xFFFFFFFE; MULH -> 0x00000000.
REQ-034 DIV -20/3 -> stall high T..T+32, at T+33 result=0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2).
REQ-035 DIVU 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-036 Flush at T+10 of a DIV -> IDLE at T+11, no result_valid; next ADD accepted at T+11 with a correct result.
REQ-037 rst_n pulse mid-MUL -> stall and valid drop at once, result=0; a subsequent MUL 3*4 -> 12.
